// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader writing words to instruction memory, holding the core until done.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_END = S_CSUM;
  logic [7:0] csum;
`else
  localparam logic [2:0] S_END = S_DONE;
`endif
  logic [2:0]  state, state_nx;
  logic [15:0] count, count_nx;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic        xfer, last_word;
  assign xfer       = in_valid & in_ready;
  assign count_nx   = {in_data, count[7:0]};
  assign last_word  = words_loaded + 16'd1 == count;
  assign imem_wr_en = state == S_WRITE;
  assign cpu_hold   = state != S_DONE;
  assign done       = state == S_DONE;
  assign error      = state == S_ERROR;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = xfer && in_data == SYNC_BYTE ? S_LEN0 : S_IDLE;
      S_LEN0:  state_nx = xfer ? S_LEN1 : S_LEN0;
      S_LEN1:  if (xfer) state_nx = 32'(count_nx) > DEPTH_WORDS ? S_ERROR : count_nx == 16'd0 ? S_END : S_DATA;
      S_DATA:  state_nx = xfer && byte_idx == 2'd3 ? S_WRITE : S_DATA;
      S_WRITE: state_nx = last_word ? S_END : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  if (xfer) state_nx = in_data == csum ? S_DONE : S_ERROR;
`endif
      S_DONE, S_ERROR: state_nx = clear ? S_IDLE : state;
      default: state_nx = S_IDLE;
    endcase
  end
  // in_ready is registered from the next state so WRITE/DONE/ERROR back-pressure without a combinational path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      count        <= '0;
      byte_idx     <= '0;
      word         <= '0;
      imem_wr_addr <= BASE_ADDR;
      imem_wr_data <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      state    <= state_nx;
      in_ready <= state_nx inside {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM};
      if (xfer && state == S_IDLE && in_data == SYNC_BYTE) begin
        words_loaded <= '0;
        byte_idx     <= '0;
      end
      if (xfer && state == S_LEN0) count[7:0] <= in_data;
      if (xfer && state == S_LEN1) count[15:8] <= in_data;
      if (xfer && state == S_DATA) begin
        byte_idx <= byte_idx + 2'd1;
        word[{byte_idx, 3'b000} +: 8] <= in_data;
        if (byte_idx == 2'd3) begin
          imem_wr_data <= {in_data, word[23:0]};
          imem_wr_addr <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
        end
      end
`ifdef LOADER_CHECKSUM_EN
      if (xfer && state == S_IDLE) csum <= '0;
      if (xfer && state inside {S_LEN0, S_LEN1, S_DATA}) csum <= csum ^ in_data;
`endif
      if (state == S_WRITE) words_loaded <= words_loaded + 16'd1;
      if (clear && (state == S_DONE || state == S_ERROR)) words_loaded <= '0;
    end
  end
endmodule
